// File: rtl/arbitro_mem_dados_if.sv
// Bundle of signals between the data-memory arbiter, its two requesters
// (CPU load/store path and ES display path) and the single-port memory.
//   master : requesters + memory side (drives requests, mem_saida)
//   slave  : arbiter side (drives grants, read data, memory port, parar_pc)
interface arbitro_mem_dados_if #(
  parameter int LARGURA_END  = 8,
  parameter int LARGURA_DADO = 32
);
  logic                    cpu_req;
  logic                    cpu_we;
  logic [LARGURA_END-1:0]  cpu_end;
  logic [LARGURA_DADO-1:0] cpu_dado;
  logic                    cpu_gnt;
  logic                    cpu_valido;
  logic [LARGURA_DADO-1:0] cpu_saida;

  logic                    es_req;
  logic [LARGURA_END-1:0]  es_end;
  logic                    es_gnt;
  logic                    es_valido;
  logic [LARGURA_DADO-1:0] es_saida;

  logic [LARGURA_END-1:0]  mem_end;
  logic [LARGURA_DADO-1:0] mem_dado;
  logic                    mem_hab_esc;
  logic [LARGURA_DADO-1:0] mem_saida;

  logic                    parar_pc;

  modport master (
    output cpu_req, cpu_we, cpu_end, cpu_dado, es_req, es_end, mem_saida,
    input  cpu_gnt, cpu_valido, cpu_saida, es_gnt, es_valido, es_saida,
    input  mem_end, mem_dado, mem_hab_esc, parar_pc
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_end, cpu_dado, es_req, es_end, mem_saida,
    output cpu_gnt, cpu_valido, cpu_saida, es_gnt, es_valido, es_saida,
    output mem_end, mem_dado, mem_hab_esc, parar_pc
  );
endinterface

// File: rtl/arbitro_mem_dados.sv
// Shares the single-port data memory between the CPU (read/write) and the
// ES display path (read-only). Registered one-cycle grants, CPU priority
// with an anti-starvation bound for ES, 2-cycle read return with per-port
// valid strobes, and a PC hold request while a CPU access is pending.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : arbiter view (slave modport) of arbitro_mem_dados_if
//
// state | meaning
// LIVRE | no grant this cycle, memory idle
// CPU   | CPU owns the memory port this cycle
// ES    | ES owns the memory port this cycle
module arbitro_mem_dados #(
  parameter int LARGURA_END  = 8,
  parameter int LARGURA_DADO = 32,
  parameter int MAX_ESPERA   = 4
) (
  input logic               clk,
  input logic               reset,
  arbitro_mem_dados_if.slave bus
);

  localparam logic [2:0] LIVRE = 3'b001;
  localparam logic [2:0] CPU   = 3'b010;
  localparam logic [2:0] ES    = 3'b100;

  localparam logic [3:0] ESPERA_MAX = 4'(MAX_ESPERA);

  logic [2:0]              estado, prox;
  logic [3:0]              espera, espera_prox;

  logic [LARGURA_END-1:0]  end_q;
  logic [LARGURA_DADO-1:0] dado_q;
  logic                    hab_esc_q;

  // stage 1: read in the memory-latency cycle; {valido, porta}, porta=1 is ES
  logic                    lat_valido, lat_porta;
  logic                    leitura_agora;

  logic                    cpu_valido_q, es_valido_q;
  logic [LARGURA_DADO-1:0] cpu_saida_q, es_saida_q;

  always_comb begin
    prox = LIVRE;
    if (bus.cpu_req && bus.es_req)
      prox = (espera >= ESPERA_MAX) ? ES : CPU;
    else if (bus.cpu_req)
      prox = CPU;
    else if (bus.es_req)
      prox = ES;
  end

  always_comb begin
    espera_prox = espera;
    if (prox == ES)
      espera_prox = 4'd0;
    else if (bus.es_req && (espera < ESPERA_MAX))
      espera_prox = espera + 4'd1;
  end

  assign leitura_agora = (estado == ES) || ((estado == CPU) && !hab_esc_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado    <= LIVRE;
      espera    <= 4'd0;
      end_q     <= '0;
      dado_q    <= '0;
      hab_esc_q <= 1'b0;
    end else begin
      estado <= prox;
      espera <= espera_prox;
      case (prox)
        CPU: begin
          end_q     <= bus.cpu_end;
          dado_q    <= bus.cpu_dado;
          hab_esc_q <= bus.cpu_we;
        end
        ES: begin
          end_q     <= bus.es_end;
          dado_q    <= '0;
          hab_esc_q <= 1'b0;
        end
        default: begin
          end_q     <= '0;
          dado_q    <= '0;
          hab_esc_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_valido   <= 1'b0;
      lat_porta    <= 1'b0;
      cpu_valido_q <= 1'b0;
      es_valido_q  <= 1'b0;
      cpu_saida_q  <= '0;
      es_saida_q   <= '0;
    end else begin
      lat_valido   <= leitura_agora;
      lat_porta    <= (estado == ES);
      cpu_valido_q <= lat_valido && !lat_porta;
      es_valido_q  <= lat_valido && lat_porta;
      if (lat_valido && !lat_porta)
        cpu_saida_q <= bus.mem_saida;
      if (lat_valido && lat_porta)
        es_saida_q <= bus.mem_saida;
    end
  end

  assign bus.cpu_gnt     = (estado == CPU);
  assign bus.es_gnt      = (estado == ES);
  assign bus.mem_end     = end_q;
  assign bus.mem_dado    = dado_q;
  // only a CPU grant can carry a write; the latch is cleared otherwise
  assign bus.mem_hab_esc = hab_esc_q && (estado == CPU);
  assign bus.cpu_valido  = cpu_valido_q;
  assign bus.es_valido   = es_valido_q;
  assign bus.cpu_saida   = cpu_saida_q;
  assign bus.es_saida    = es_saida_q;

  // Gated by reset so the hold request is low while reset is asserted,
  // even if the CPU is already requesting.
  assign bus.parar_pc = reset &&
                        ((bus.cpu_req && (estado != CPU)) ||
                         ((estado == CPU) && !hab_esc_q) ||
                         (lat_valido && !lat_porta));

endmodule
